// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: grants one requester a burst of beats toward a
// single consumer, releasing on last, on the beat cap, or on request withdrawal.
module rr_arbiter8 #(
    parameter int MAX_BEATS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out_valid,
    output logic       busy
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] CAP = CW'(MAX_BEATS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r;
    logic [2:0]      ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_inc_s;
    logic            acc_s;
    logic            cap_hit_s;
    logic            release_s;
    logic [3:0]      pick_s;

    // Search ptr+1 .. ptr+8 (mod 8); the pointer itself comes last. Result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            idx = p + 3'(i);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign out_valid = busy & req[sel];

    // Beat acceptance, cap detection and release decision for the held grant.
    always_comb begin
        acc_s     = out_valid & out_ready;
        cnt_inc_s = cnt_r + CW'(1);
        cap_hit_s = (cnt_inc_s == CAP);
        release_s = 1'b0;
        if (!req[sel]) begin
            release_s = 1'b1;
        end else if (acc_s && (last[sel] || cap_hit_s)) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
    end

    // Round-robin winner among current requests, relative to the last grant.
    always_comb begin
        pick_s = rr_pick(req, ptr_r);
    end

    // Arbitration FSM with registered grant, select and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            gnt     <= 8'h00;
            sel     <= 3'd0;
            busy    <= 1'b0;
            ptr_r   <= 3'd7;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_s[3]) begin
                        state_r <= GRANT;
                        gnt     <= 8'h01 << pick_s[2:0];
                        sel     <= pick_s[2:0];
                        busy    <= 1'b1;
                        ptr_r   <= pick_s[2:0];
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        state_r <= IDLE;
                        gnt     <= 8'h00;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                    end else if (acc_s) begin
                        cnt_r   <= cnt_inc_s;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= 8'h00;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic
// compared every cycle against a behavioural grant/burst model.
module tb_rr_arbiter8;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] last = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: who holds the grant, how many beats it has had.
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_cnt;
    int grant_q[$];
    int beats_q[$];

    rr_arbiter8 #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .out_ready(out_ready),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_idx = 0; m_ptr = 7; m_cnt = 0;
        grant_q.delete();
        beats_q.delete();
    endtask

    task automatic compare_model();
        logic [7:0] eg;
        eg = m_busy ? (8'h01 << m_idx) : 8'h00;
        check("gnt", gnt, eg);
        check("sel", sel, m_idx);
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_busy && req[m_idx]);
    endtask

    task automatic expect_out(input logic [7:0] g, input int s, input bit b, input bit v);
        check("lit_gnt", gnt, g);
        check("lit_sel", sel, s);
        check("lit_busy", busy, b);
        check("lit_valid", out_valid, v);
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic o);
        @(negedge clk);
        req = r; last = l; out_ready = o;
        #1;
        compare_model();
    endtask

    task automatic step();
        bit found;
        @(posedge clk);
        if (m_busy) begin
            if (!req[m_idx]) begin
                beats_q.push_back(m_cnt);
                m_busy = 1'b0; m_cnt = 0;
            end else if (out_ready) begin
                m_cnt++;
                if (last[m_idx] || m_cnt == MAXB) begin
                    beats_q.push_back(m_cnt);
                    m_busy = 1'b0; m_cnt = 0;
                end
            end
        end else if (req != 8'h00) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    found = 1'b1;
                    m_idx = (m_ptr + k) % 8;
                end
            end
            m_ptr = m_idx; m_busy = 1'b1; m_cnt = 0;
            grant_q.push_back(m_idx);
        end
    endtask

    task automatic cyc(input logic [7:0] r, input logic [7:0] l, input logic o);
        drive(r, l, o);
        step();
    endtask

    // Asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; req = 8'h00; last = 8'h00; out_ready = 1'b0;
        #1;
        expect_out(8'h00, 0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        #12;
        expect_out(8'h00, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // Single-beat grant to requester 0.
        reset_dut();
        drive(8'h01, 8'h01, 1'b1); expect_out(8'h00, 0, 1'b0, 1'b0); step();
        drive(8'h01, 8'h01, 1'b1); expect_out(8'h01, 0, 1'b1, 1'b1); step();
        drive(8'h00, 8'h00, 1'b1); expect_out(8'h00, 0, 1'b0, 1'b0); step();

        // All requesting, one-beat bursts: rotation 0..7,0.
        reset_dut();
        repeat (20) cyc(8'hFF, 8'hFF, 1'b1);
        check("rot_count", grant_q.size() >= 9, 1);
        for (int k = 0; k < 9 && k < grant_q.size(); k++) check("rot_order", grant_q[k], k % 8);
        for (int k = 0; k < 8 && k < beats_q.size(); k++) check("rot_beats", beats_q[k], 1);

        // Beat cap forces release: 2,3,2 with 4 beats each.
        reset_dut();
        repeat (30) cyc(8'h0C, 8'h00, 1'b1);
        check("cap_count", (grant_q.size() >= 3) && (beats_q.size() >= 2), 1);
        if (grant_q.size() >= 3) begin
            check("cap_g0", grant_q[0], 2);
            check("cap_g1", grant_q[1], 3);
            check("cap_g2", grant_q[2], 2);
        end
        if (beats_q.size() >= 2) begin
            check("cap_b0", beats_q[0], 4);
            check("cap_b1", beats_q[1], 4);
        end

        // Stall on requester 5, then a last beat.
        reset_dut();
        cyc(8'h20, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(8'h20, 8'h00, 1'b0); expect_out(8'h20, 5, 1'b1, 1'b1); step();
        end
        cyc(8'h20, 8'h20, 1'b1);
        drive(8'h00, 8'h00, 1'b1); expect_out(8'h00, 5, 1'b0, 1'b0); step();
        check("stall_beats", (beats_q.size() == 1) ? beats_q[0] : -1, 1);

        // Requester 6 withdraws after two beats; requester 1 wins next.
        reset_dut();
        cyc(8'h40, 8'h00, 1'b1);
        cyc(8'h42, 8'h00, 1'b1);
        cyc(8'h42, 8'h00, 1'b1);
        drive(8'h02, 8'h00, 1'b1); expect_out(8'h40, 6, 1'b1, 1'b0); step();
        drive(8'h02, 8'h00, 1'b1); expect_out(8'h00, 6, 1'b0, 1'b0); step();
        drive(8'h02, 8'h02, 1'b1); expect_out(8'h02, 1, 1'b1, 1'b1); step();
        check("wd_beats", (beats_q.size() >= 1) ? beats_q[0] : -1, 2);

        // Reset mid-burst after two beats; then requester 0 beats 7 and gets a full fresh cap.
        reset_dut();
        cyc(8'h01, 8'h00, 1'b1);
        cyc(8'h01, 8'h00, 1'b1);
        cyc(8'h01, 8'h00, 1'b1);
        reset_dut();
        drive(8'h81, 8'h00, 1'b1); step();
        drive(8'h81, 8'h00, 1'b1); expect_out(8'h01, 0, 1'b1, 1'b1); step();
        repeat (8) cyc(8'h81, 8'h00, 1'b1);
        check("rst_beats", (beats_q.size() >= 1) ? beats_q[0] : -1, 4);
        check("rst_next", (grant_q.size() >= 2) ? grant_q[1] : -1, 7);

        // Randomized traffic against the model.
        reset_dut();
        begin
            logic [7:0] r;
            logic [7:0] l;
            logic       o;
            r = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 3) == 0) r = 8'($urandom);
                l = 8'($urandom) & 8'($urandom);
                o = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 499) == 0) reset_dut();
                else cyc(r, l, o);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one 8:1 datapath mux and its single downstream consumer between eight requesters. It drives the mux select and a one-hot grant, holds a grant for a burst of beats ending on a `last` flag or a beat cap, and exposes a valid/ready handshake toward the consumer. It sits in the riscv32i core between the eight source ports and the shared sink, which is for example a writeback or memory-request port.

## Interface

- `MAX_BEATS`, default 4: maximum accepted beats per grant. Legal range 1..255.
- `clk`  in  1: clock. All state is updated on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  8: `req[i]` is high while requester i has a beat to present.
- `last`  in  8: `last[i]` marks the current beat of requester i as the final beat of its burst.
- `out_ready`  in  1: the consumer accepts the presented beat.
- `gnt`  out  8: one-hot grant, or all zeros when no grant is held. Registered.
- `sel`  out  3: mux select, equal to the index of the granted requester. Registered.
- `out_valid`  out  1: a beat is presented to the consumer. Combinational: `out_valid = busy & req[sel]`.
- `busy`  out  1: a grant is held. Registered.

## Operation

- State machine has two states, IDLE and GRANT. Internal registers:
  - `ptr` (3 bits): last granted index.
  - `cnt`: accepted-beat counter, width $clog2(MAX_BEATS+1).
- A beat is accepted (`acc`) when `out_valid & out_ready`.
- IDLE behaviour:
  - If `req` is nonzero, choose the first set bit searching ptr+1, ptr+2, … with indices mod 8; ptr itself is searched last.
  - Next edge: enter GRANT, set `gnt` one-hot, `sel` = winner, `busy` = 1, `ptr` = winner, `cnt` = 0.
  - If `req` is zero, stay in IDLE with outputs unchanged at their idle values.
- GRANT behaviour:
  - On each `acc`, `cnt` increments.
  - Release to IDLE on the next edge when any of the following holds:
    - (a) `acc & last[sel]`;
    - (b) `acc` and `cnt+1 == MAX_BEATS`, a forced release even without `last`;
    - (c) `req[sel] == 0`, meaning the requester withdrew. The requester may withdraw only between beats; an un-accepted beat is dropped.
  - On release: `gnt` = 0, `busy` = 0, `cnt` = 0, `sel` holds its value, `ptr` holds.
- Release always returns through IDLE, so there is exactly one bubble cycle between grants. Arbitration happens in that IDLE cycle.
- `req`/`last` of non-granted requesters are ignored during GRANT.
- `sel` and `gnt` never change while in GRANT.
- Reset values: IDLE, `gnt`=0, `sel`=0, `busy`=0, `out_valid`=0, `ptr`=7 (so requester 0 has top priority first), `cnt`=0.
- Reset asserted mid-burst aborts the grant immediately (asynchronously). The in-flight beat is not counted.

## Timing

- Grant latency: `req` sampled high in IDLE at edge n → `gnt`/`sel`/`busy` valid after edge n, so `out_valid` is high in cycle n+1.
- Throughput: one beat per cycle within a burst while `out_ready`=1. A burst of B beats occupies B cycles plus one IDLE cycle.
- `out_ready` low stalls: `cnt` and the grant hold indefinitely. There is no timeout.
- A `last` beat and the `MAX_BEATS` cap reached together produce a single release.
- `last[sel]` without `acc` has no effect.
- Simultaneous new requests arriving during the release edge are seen in the following IDLE cycle.
- `out_valid` has a combinational path from `req[sel]`. The other outputs are register-only.

## Test plan

- Reset, then `req`=8'h01, `last`=8'h01, `out_ready`=1 → `gnt`=8'h01, `sel`=0, one beat accepted, `busy` low on the next edge; total 2 cycles from request to IDLE.
- `req`=8'hFF held, `last`=8'hFF, `out_ready`=1 → grant order 0,1,2,…,7,0. Each grant lasts one beat followed by one IDLE cycle; `sel` sequence matches.
- `MAX_BEATS`=4, `req`=8'h0C held, `last`=0 → requester 2 gets exactly 4 beats, then forced release; requester 3 gets the next 4; then back to 2.
- Requester 5 granted, `out_ready`=0 for 10 cycles → `out_valid`=1 and `cnt`=0 throughout, `gnt`=8'h20 stable. `out_ready`=1 with `last[5]`=1 → release after 1 beat.
- Requester 6 granted, `req[6]` dropped after 2 accepted beats → release on the next edge. Pending `req[1]` then wins, since the search order from ptr=6 is 7,0,1.
- `reset` pulsed mid-burst with `cnt`=2 → `gnt`=0, `busy`=0, `out_valid`=0 immediately. After reset, with `req`=8'h81, requester 0 wins.
